free_list: RTL and testbench

FREE_LIST -- requirements
Module: free_list

---
 rtl/free_list_pkg.sv | 18 +
 rtl/free_list.sv | 97 +++++++++
 tb/tb_free_list.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/free_list_pkg.sv
//==============================================================================
// Module   : free_list_pkg
// Brief    : Shared register-file sizing and physical tag type.
// Revision : 1.0
//==============================================================================
`default_nettype none

package free_list_pkg;

  localparam int FL_NUM_PHYS_REGS = 64;
  localparam int FL_NUM_ARCH_REGS = 32;
  localparam int FL_TAG_W         = $clog2(FL_NUM_PHYS_REGS);

  typedef logic [FL_TAG_W-1:0] phys_tag_t;

endpackage

`default_nettype wire

// File: rtl/free_list.sv
//==============================================================================
// Module   : free_list
// Brief    : Circular free list of physical register tags with one-deep
//            branch checkpoint of the head pointer.
// Revision : 1.0
//==============================================================================
`default_nettype none

module free_list
  import free_list_pkg::*;
#(
  parameter  int NUM_PHYS_REGS = FL_NUM_PHYS_REGS,
  parameter  int NUM_ARCH_REGS = FL_NUM_ARCH_REGS,
  localparam int DEPTH         = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int TAG_W         = $clog2(NUM_PHYS_REGS)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alloc_req,
  output logic             alloc_valid,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             free_en,
  input  logic [TAG_W-1:0] free_tag,
  input  logic             ckpt_en,
  input  logic             rollback,
  output logic [TAG_W-1:0] free_count,
  output logic             empty,
  output logic             full,
  output logic             free_err
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam int               PTR_W    = IDX_W + 1;
  localparam logic [PTR_W-1:0] TAIL_RST = PTR_W'(DEPTH);

  logic [TAG_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] r_ckpt_head;
  logic             r_free_err;

  logic [PTR_W-1:0] w_count;
  logic             w_empty;
  logic             w_full;
  logic             w_alloc_go;
  logic             w_free_go;
  logic [PTR_W-1:0] w_head_next;

  // Pointers carry a wrap bit, so the plain difference is the occupancy.
  assign w_count    = r_tail - r_head;
  assign w_empty    = (w_count == '0);
  assign w_full     = (w_count == TAIL_RST);
  assign w_alloc_go = alloc_req && !w_empty && !rollback;
  assign w_free_go  = free_en && !w_full;

  always_comb begin
    w_head_next = r_head;
    if (rollback) begin
      w_head_next = r_ckpt_head;
    end else if (w_alloc_go) begin
      w_head_next = r_head + PTR_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= TAG_W'(NUM_ARCH_REGS + i);
      end
      r_head      <= '0;
      r_tail      <= TAIL_RST;
      r_ckpt_head <= '0;
      r_free_err  <= 1'b0;
    end else begin
      r_head <= w_head_next;
      if (w_free_go) begin
        r_mem[r_tail[IDX_W-1:0]] <= free_tag;
        r_tail                   <= r_tail + PTR_W'(1);
      end
      // Checkpoint holds the post-alloc head; a mispredict takes priority.
      if (ckpt_en && !rollback) begin
        r_ckpt_head <= w_head_next;
      end
      r_free_err <= free_en && w_full;
    end
  end

  assign alloc_tag   = r_mem[r_head[IDX_W-1:0]];
  assign alloc_valid = !w_empty;
  assign free_count  = TAG_W'(w_count);
  assign empty       = w_empty;
  assign full        = w_full;
  assign free_err    = r_free_err;

endmodule

`default_nettype wire

// File: tb/tb_free_list.sv
//==============================================================================
// Module   : tb_free_list
// Brief    : Directed vector table plus corner-case sequences for free_list.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_free_list;
  import free_list_pkg::*;

  logic      clock = 1'b0;
  logic      reset;
  logic      alloc_req;
  logic      alloc_valid;
  phys_tag_t alloc_tag;
  logic      free_en;
  phys_tag_t free_tag;
  logic      ckpt_en;
  logic      rollback;
  phys_tag_t free_count;
  logic      empty;
  logic      full;
  logic      free_err;

  int errors = 0;
  int checks = 0;

  free_list #(
    .NUM_PHYS_REGS(64),
    .NUM_ARCH_REGS(32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .alloc_req  (alloc_req),
    .alloc_valid(alloc_valid),
    .alloc_tag  (alloc_tag),
    .free_en    (free_en),
    .free_tag   (free_tag),
    .ckpt_en    (ckpt_en),
    .rollback   (rollback),
    .free_count (free_count),
    .empty      (empty),
    .full       (full),
    .free_err   (free_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       a;
    logic       f;
    logic [5:0] ft;
    logic       ck;
    logic       rb;
    logic       ev;
    logic [5:0] et;
    logic [5:0] ec;
    logic       efull;
    logic       eempty;
    logic       eerr;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    alloc_req = 1'b0;
    free_en   = 1'b0;
    free_tag  = '0;
    ckpt_en   = 1'b0;
    rollback  = 1'b0;
  endtask

  // Inputs change just after a falling edge; outputs are sampled at the next one.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_outs(input string p, input logic v, input logic [5:0] t,
                            input logic [5:0] c, input logic fu, input logic em,
                            input logic er);
    check({p, "_valid"}, 32'(alloc_valid), 32'(v));
    if (v) check({p, "_tag"}, 32'(alloc_tag), 32'(t));
    check({p, "_count"}, 32'(free_count), 32'(c));
    check({p, "_full"},  32'(full),       32'(fu));
    check({p, "_empty"}, 32'(empty),      32'(em));
    check({p, "_err"},   32'(free_err),   32'(er));
  endtask

  initial begin
    phys_tag_t q[$];
    logic [5:0] ft;

    //          a  f  ft  ck rb  ev  et  ec  fu em er
    vecs[0]  = '{0, 1,  5, 0, 0,  1, 32, 32, 1, 0, 1};  // free while full
    vecs[1]  = '{0, 0,  0, 0, 0,  1, 32, 32, 1, 0, 0};  // err is one cycle only
    vecs[2]  = '{1, 0,  0, 0, 0,  1, 33, 31, 0, 0, 0};
    vecs[3]  = '{1, 0,  0, 0, 0,  1, 34, 30, 0, 0, 0};
    vecs[4]  = '{1, 0,  0, 0, 0,  1, 35, 29, 0, 0, 0};
    vecs[5]  = '{1, 0,  0, 1, 0,  1, 36, 28, 0, 0, 0};  // ckpt with 4th alloc -> 4
    vecs[6]  = '{1, 0,  0, 0, 0,  1, 37, 27, 0, 0, 0};
    vecs[7]  = '{1, 0,  0, 0, 0,  1, 38, 26, 0, 0, 0};
    vecs[8]  = '{1, 0,  0, 0, 1,  1, 36, 28, 0, 0, 0};  // rollback ignores alloc
    vecs[9]  = '{1, 0,  0, 0, 0,  1, 37, 27, 0, 0, 0};
    vecs[10] = '{1, 0,  0, 1, 1,  1, 36, 28, 0, 0, 0};  // rollback beats ckpt
    vecs[11] = '{1, 0,  0, 0, 0,  1, 37, 27, 0, 0, 0};
    vecs[12] = '{0, 0,  0, 0, 1,  1, 36, 28, 0, 0, 0};  // second rollback -> 4
    vecs[13] = '{0, 1,  7, 0, 1,  1, 36, 29, 0, 0, 0};  // free survives rollback
    vecs[14] = '{1, 1,  9, 0, 0,  1, 37, 29, 0, 0, 0};  // alloc+free together

    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    tick();
    reset = 1'b1;
    check_outs("reset", 1'b1, 6'd32, 6'd32, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 15; i++) begin
      alloc_req = vecs[i].a;
      free_en   = vecs[i].f;
      free_tag  = vecs[i].ft;
      ckpt_en   = vecs[i].ck;
      rollback  = vecs[i].rb;
      tick();
      check_outs($sformatf("v%0d", i), vecs[i].ev, vecs[i].et, vecs[i].ec,
                 vecs[i].efull, vecs[i].eempty, vecs[i].eerr);
    end

    // Reset mid-run overrides rollback, free and alloc in the same cycle.
    reset     = 1'b0;
    alloc_req = 1'b1;
    free_en   = 1'b1;
    free_tag  = 6'd3;
    rollback  = 1'b1;
    ckpt_en   = 1'b1;
    tick();
    reset = 1'b1;
    idle_inputs();
    check_outs("midrst", 1'b1, 6'd32, 6'd32, 1'b1, 1'b0, 1'b0);

    // Drain all 32 tags in order.
    for (int i = 0; i < 32; i++) begin
      check($sformatf("drain%0d_tag", i), 32'(alloc_tag), 32'(32 + i));
      alloc_req = 1'b1;
      tick();
    end
    alloc_req = 1'b0;
    check_outs("drained", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    alloc_req = 1'b1;
    tick();
    check_outs("alloc_empty", 1'b0, 6'd0, 6'd0, 1'b0, 1'b1, 1'b0);

    // No bypass: the freed tag becomes visible only next cycle.
    free_en  = 1'b1;
    free_tag = 6'd40;
    tick();
    idle_inputs();
    check_outs("nobypass", 1'b1, 6'd40, 6'd1, 1'b0, 1'b0, 1'b0);

    q.push_back(6'd40);
    for (int k = 0; k < 64; k++) begin
      ft = 6'((k * 7 + 3) % 64);
      check($sformatf("stream%0d_tag", k), 32'(alloc_tag), 32'(q[0]));
      check($sformatf("stream%0d_count", k), 32'(free_count), 32'd1);
      alloc_req = 1'b1;
      free_en   = 1'b1;
      free_tag  = ft;
      tick();
      void'(q.pop_front());
      q.push_back(ft);
    end
    idle_inputs();
    check_outs("stream_end", 1'b1, q[0], 6'd1, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
